// File: rtl/xita_to_duty.sv
// Servo angle (sign-magnitude Q15.16 degrees) to 50 Hz PWM high-time count.
// One conversion every 24 clocks: sample, 22-step serial divide, load duty.
module xita_to_duty #(
  parameter int CENTER  = 75000,
  parameter int SPAN    = 50000,
  parameter int MAX_DEG = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] xita,
  output logic [19:0] duty
);

  // SPAN/MAX_DEG reduced by their common factor keeps the divisor small (45).
  localparam int          MUL     = SPAN / 2;
  localparam int          DIV     = MAX_DEG / 2;
  localparam logic [30:0] MAG_MAX = 31'(MAX_DEG) << 16;
  localparam logic [4:0]  LAST    = 5'd23;

  logic [4:0]  phase;
  logic [31:0] xita_p0;
  logic [21:0] qd_p1;
  logic [5:0]  rem_p1;

  logic [30:0] mag_c;
  logic [37:0] prod;
  logic [21:0] s_p0;
  logic [21:0] qd_in;
  logic [21:0] qd_nxt;
  logic [5:0]  rem_in;
  logic [5:0]  rem_nxt;
  logic [6:0]  trial;

  function automatic logic [30:0] sat_mag(input logic [30:0] m);
    return (m > MAG_MAX) ? MAG_MAX : m;
  endfunction

  // Offset from centre; q never exceeds SPAN so the 20-bit result cannot wrap.
  function automatic logic [19:0] apply_sign(input logic neg, input logic [15:0] q);
    logic signed [20:0] mag_s;
    logic signed [20:0] res;
    mag_s = $signed({5'd0, q});
    res   = neg ? ($signed(21'(CENTER)) - mag_s) : ($signed(21'(CENTER)) + mag_s);
    return res[19:0];
  endfunction

  always_comb begin
    mag_c   = sat_mag(xita_p0[30:0]);
    prod    = 38'(mag_c) * 38'(MUL);
    s_p0    = 22'(prod >> 16);
    qd_in   = (phase == 5'd1) ? s_p0 : qd_p1;
    rem_in  = (phase == 5'd1) ? 6'd0 : rem_p1;
    trial   = {rem_in, qd_in[21]};
    rem_nxt = trial[5:0];
    qd_nxt  = {qd_in[20:0], 1'b0};
    if (trial >= 7'(DIV)) begin
      rem_nxt   = 6'(trial - 7'(DIV));
      qd_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      xita_p0 <= '0;
      qd_p1   <= '0;
      rem_p1  <= '0;
      duty    <= 20'(CENTER);
    end else begin
      phase <= (phase == LAST) ? 5'd0 : phase + 5'd1;
      // stage p0: capture command
      if (phase == 5'd0)
        xita_p0 <= xita;
      // stage p1: one restoring-divide bit per clock
      if (phase >= 5'd1 && phase <= 5'd22) begin
        qd_p1  <= qd_nxt;
        rem_p1 <= rem_nxt;
      end
      // stage p2: signed offset from centre
      if (phase == LAST)
        duty <= apply_sign(xita_p0[31], 16'(qd_p1));
    end
  end

endmodule

// File: tb/tb_xita_to_duty.sv
// Self-checking bench for xita_to_duty: directed corner values, random
// commands against an arithmetic model, latency and mid-conversion reset.
module tb_xita_to_duty;

  logic        clk;
  logic        rst_n;
  logic [31:0] xita;
  logic [19:0] duty;

  int nvec;
  int nerr;
  int edges;

  xita_to_duty dut (
    .clk  (clk),
    .rst_n(rst_n),
    .xita (xita),
    .duty (duty)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // rising edges since reset release; the next edge handles phase edges%24
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic int ref_duty(input logic [31:0] x);
    longint m;
    longint q;
    m = longint'(x[30:0]);
    if (m > 90 * 65536) m = 90 * 65536;
    q = ((m * 25000) / 65536) / 45;
    return x[31] ? int'(75000 - q) : int'(75000 + q);
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: duty=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    while ((edges % 24) != p && guard < 30) begin
      tick(1);
      guard++;
    end
    if (guard >= 30) chk("phase_timeout", guard, 0);
  endtask

  task automatic do_reset(input logic [31:0] x);
    @(posedge clk);
    #1;
    xita  = x;
    rst_n = 1'b0;
    tick(3);
    chk("in_reset", int'(duty), 75000);
    rst_n = 1'b1;
  endtask

  logic [31:0] dir_x [8] = '{32'h0000_0000, 32'h002D_0000, 32'h005A_0000, 32'h0060_0000,
                             32'h8064_0000, 32'h802D_0000, 32'h805A_0000, 32'h0000_8000};
  int          dir_d [8] = '{75000, 100000, 125000, 125000, 25000, 50000, 25000, 75277};

  initial begin
    logic [31:0] x;
    logic [31:0] xo;
    logic [31:0] xn;
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    xita  = '0;

    do_reset(32'h0000_0000);
    tick(48);
    chk("zero_after_48", int'(duty), 75000);

    // first update lands exactly on the 24th edge after release
    do_reset(32'h002D_0000);
    tick(23);
    chk("before_24th", int'(duty), 75000);
    tick(1);
    chk("at_24th", int'(duty), 100000);

    for (int i = 0; i < 8; i++) begin
      xita = dir_x[i];
      tick(48);
      chk($sformatf("dir_%08h", dir_x[i]), int'(duty), dir_d[i]);
    end
    xita = 32'h8000_8000;
    tick(48);
    chk("frac_neg", int'(duty), 74723);
    xita = 32'h8000_0000;
    tick(48);
    chk("neg_zero", int'(duty), 75000);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       x = $urandom;
        1:       x = {1'($urandom), 31'($urandom_range(0, 32'h0064_0000))};
        2:       x = {1'($urandom), 15'($urandom_range(88, 92)), 16'($urandom)};
        default: x = {1'($urandom), 15'd0, 16'($urandom)};
      endcase
      tick($urandom_range(0, 23));
      xita = x;
      tick(48);
      chk($sformatf("rand_%08h", x), int'(duty), ref_duty(x));
    end

    // latency: step at phase 1 is ignored until the next conversion
    xo   = 32'h0012_3456;
    xn   = 32'h8034_0000;
    xita = xo;
    tick(48);
    wait_phase(1);
    xita = xn;
    wait_phase(23);
    chk("hold_old_a", int'(duty), ref_duty(xo));
    tick(1);
    chk("first_upd_old", int'(duty), ref_duty(xo));
    tick(23);
    chk("hold_old_b", int'(duty), ref_duty(xo));
    tick(1);
    chk("second_upd_new", int'(duty), ref_duty(xn));

    // reset mid-conversion returns duty to centre at once
    wait_phase(10);
    xita = 32'h0050_0000;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", int'(duty), 75000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(23);
    chk("post_reset_hold", int'(duty), 75000);
    tick(1);
    chk("post_reset_upd", int'(duty), ref_duty(32'h0050_0000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
